// File: rtl/quant_gain_sequencer_pkg.sv
// Shared definitions for the quantizer gain sequencer.
// Holds the command op-codes, the sequencer state encoding, the status_word
// bit positions and a helper that packs the status word.
package quant_gain_sequencer_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_FILL    = 2'b01;
    localparam logic [1:0] OP_COMMIT  = 2'b10;
    localparam logic [1:0] OP_CLR_ERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_ARM  = 2'd2
    } seq_state_e;

    localparam int STAT_BUSY = 31;
    localparam int STAT_PEND = 30;
    localparam int STAT_ERR  = 29;
    localparam int STAT_BANK = 28;
    localparam int CNT_W     = 16;

    function automatic logic [31:0] pack_status(
        input logic             busy_bit,
        input logic             pend_bit,
        input logic             err_bit,
        input logic             bank_bit,
        input logic [CNT_W-1:0] cnt
    );
        logic [31:0] word;
        word            = '0;
        word[STAT_BUSY] = busy_bit;
        word[STAT_PEND] = pend_bit;
        word[STAT_ERR]  = err_bit;
        word[STAT_BANK] = bank_bit;
        word[CNT_W-1:0] = cnt;
        return word;
    endfunction

endpackage

// File: rtl/quant_gain_sequencer_ram.sv
// gain_bank_ram: one gain bank, simple dual-port.
// One synchronous write port and one read port with a registered output
// (one cycle from raddr to rdata). Contents are deliberately not reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - registered read data
module gain_bank_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/quant_gain_sequencer.sv
// Quantizer gain sequencer with double-buffered gain banks.
// Software posts commands through cmd_word (edge of bit 31 marks a new
// command). Writes always land in the shadow bank; a commit arms a bank swap
// that takes effect on the next frame sync so the datapath never sees a
// half-updated table.
// Ports:
//   OPB_Clk     - sole clock, rising edge
//   OPB_Rst     - asynchronous active-high reset
//   cmd_word    - [31] toggle, [30:29] op, [16+CHAN_W-1:16] addr, [GAIN_W-1:0] gain
//   sync_in     - one-cycle frame sync from the datapath
//   rd_addr     - datapath channel read address
//   gain_out    - gain for rd_addr from the active bank, 2-cycle latency
//   active_bank - bank currently read by the datapath
//   busy        - high while filling or waiting for sync after a commit
//   status_word - registered {busy, pending, err, active_bank, 12'b0, commit_cnt}
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting commands; single writes and err clear run here
// FILL    | writing fill gain to every shadow address, one per cycle
// ARM     | commit pending, swap banks on the first sync_in
import quant_gain_sequencer_pkg::*;

module quant_gain_sequencer #(
    parameter int CHAN_W = 10,
    parameter int GAIN_W = 16
) (
    input  logic              OPB_Clk,
    input  logic              OPB_Rst,
    input  logic [31:0]       cmd_word,
    input  logic              sync_in,
    input  logic [CHAN_W-1:0] rd_addr,
    output logic [GAIN_W-1:0] gain_out,
    output logic              active_bank,
    output logic              busy,
    output logic [31:0]       status_word
);

    localparam logic [CHAN_W-1:0] FILL_LAST = '1;

    seq_state_e state_q, state_d;

    logic              tog_q;
    logic              hist_vld_q;
    logic              acc_q;
    logic [1:0]        op_q;
    logic [CHAN_W-1:0] addr_q;
    logic [GAIN_W-1:0] gain_q;

    logic              start_write;
    logic              start_fill;
    logic              do_commit;
    logic              clr_err;
    logic              drop;

    logic [CHAN_W-1:0] fill_cnt_q;
    logic [GAIN_W-1:0] fill_gain_q;
    logic              wr_pend_q;
    logic [CHAN_W-1:0] wr_addr_q;
    logic [GAIN_W-1:0] wr_data_q;
    logic              err_q;
    logic [CNT_W-1:0]  commit_cnt_q;

    logic              ram_we;
    logic [CHAN_W-1:0] ram_waddr;
    logic [GAIN_W-1:0] ram_wdata;
    logic [GAIN_W-1:0] rd_data0;
    logic [GAIN_W-1:0] rd_data1;

    // Bits outside the decoded fields are reserved and ignored.
    logic unused_cmd;
    assign unused_cmd = ^cmd_word;

    // Command capture. hist_vld_q keeps the first sample after reset from
    // being compared against the reset value of tog_q.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            tog_q      <= 1'b0;
            hist_vld_q <= 1'b0;
            acc_q      <= 1'b0;
            op_q       <= '0;
            addr_q     <= '0;
            gain_q     <= '0;
        end else begin
            tog_q      <= cmd_word[31];
            hist_vld_q <= 1'b1;
            acc_q      <= hist_vld_q & (cmd_word[31] ^ tog_q);
            op_q       <= cmd_word[30:29];
            addr_q     <= cmd_word[16 +: CHAN_W];
            gain_q     <= cmd_word[GAIN_W-1:0];
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_write = 1'b0;
        start_fill  = 1'b0;
        do_commit   = 1'b0;
        clr_err     = 1'b0;
        drop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_q) begin
                    case (op_q)
                        OP_WRITE:  start_write = 1'b1;
                        OP_FILL: begin
                            start_fill = 1'b1;
                            state_d    = ST_FILL;
                        end
                        OP_COMMIT: state_d = ST_ARM;
                        default:   clr_err = 1'b1;
                    endcase
                end
            end
            ST_FILL: begin
                drop = acc_q;
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                drop = acc_q;
                if (sync_in) begin
                    do_commit = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            fill_cnt_q   <= '0;
            fill_gain_q  <= '0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
            active_bank  <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            if (start_fill) begin
                fill_cnt_q  <= '0;
                fill_gain_q <= gain_q;
            end else if (state_q == ST_FILL) begin
                fill_cnt_q <= fill_cnt_q + 1'b1;
            end
            wr_pend_q <= start_write;
            if (start_write) begin
                wr_addr_q <= addr_q;
                wr_data_q <= gain_q;
            end
            if (drop) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
            if (do_commit) begin
                active_bank  <= ~active_bank;
                commit_cnt_q <= commit_cnt_q + 1'b1;
            end
        end
    end

    // Fill and single write never overlap: a single write only issues from
    // IDLE and completes in the following cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr_q;
        ram_wdata = wr_data_q;
        if (state_q == ST_FILL) begin
            ram_we    = 1'b1;
            ram_waddr = fill_cnt_q;
            ram_wdata = fill_gain_q;
        end else if (wr_pend_q) begin
            ram_we = 1'b1;
        end
    end

    // Only the shadow bank (~active_bank) is ever write-enabled.
    gain_bank_ram #(.ADDR_W(CHAN_W), .DATA_W(GAIN_W)) u_bank0 (
        .clk   (OPB_Clk),
        .we    (ram_we & active_bank),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data0)
    );

    gain_bank_ram #(.ADDR_W(CHAN_W), .DATA_W(GAIN_W)) u_bank1 (
        .clk   (OPB_Clk),
        .we    (ram_we & ~active_bank),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data1)
    );

    // The bank select is applied at the second stage, so a read issued in
    // the cycle after a swap already sees the new bank.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            gain_out <= '0;
        end else begin
            gain_out <= active_bank ? rd_data1 : rd_data0;
        end
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            status_word <= '0;
        end else begin
            status_word <= pack_status(busy, state_q == ST_ARM, err_q,
                                       active_bank, commit_cnt_q);
        end
    end

endmodule

// File: tb/tb_quant_gain_sequencer.sv
module tb_quant_gain_sequencer;

    localparam int CHAN_W = 10;
    localparam int GAIN_W = 16;
    localparam int NCH    = 1024;

    logic              OPB_Clk = 1'b0;
    logic              OPB_Rst;
    logic [31:0]       cmd_word;
    logic              sync_in;
    logic [CHAN_W-1:0] rd_addr;
    logic [GAIN_W-1:0] gain_out;
    logic              active_bank;
    logic              busy;
    logic [31:0]       status_word;

    quant_gain_sequencer #(.CHAN_W(CHAN_W), .GAIN_W(GAIN_W)) dut (
        .OPB_Clk     (OPB_Clk),
        .OPB_Rst     (OPB_Rst),
        .cmd_word    (cmd_word),
        .sync_in     (sync_in),
        .rd_addr     (rd_addr),
        .gain_out    (gain_out),
        .active_bank (active_bank),
        .busy        (busy),
        .status_word (status_word)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: two gain tables, which one is live, error flag, count.
    logic [15:0] mbank  [2][NCH];
    bit          mknown [2][NCH];
    bit          m_active = 1'b0;
    bit          m_err    = 1'b0;
    logic [15:0] m_cnt    = 16'd0;
    logic        tog      = 1'b0;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    rd_exp_t sb_e;
    logic    rd_req = 1'b0;
    logic    pipe0  = 1'b0;
    logic    pipe1  = 1'b0;
    int      busy_cycles = 0;

    // Monitor: a read issued in one cycle is presented on gain_out two edges later.
    always @(negedge OPB_Clk) begin
        if (busy) busy_cycles++;
        if (pipe1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL rd_underflow: read result with no expected entry");
            end else begin
                sb_e = sb_q.pop_front();
                if (gain_out !== sb_e.data) begin
                    n_errors++;
                    $display("FAIL rd_data addr=%0d: got %h expected %h", sb_e.addr, gain_out, sb_e.data);
                end
            end
        end
        pipe1 = pipe0;
        pipe0 = rd_req;
    end

    task automatic tick();
        @(posedge OPB_Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input int addr, input logic [15:0] g);
        tog            = ~tog;
        cmd_word       = '0;
        cmd_word[31]   = tog;
        cmd_word[30:29] = op;
        cmd_word[25:16] = addr[9:0];
        cmd_word[15:0] = g;
        tick();
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        tick();
        while (busy && n < bound) begin
            tick();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, bound);
        end
    endtask

    task automatic model_fill(input logic [15:0] g);
        for (int i = 0; i < NCH; i++) begin
            mbank[~m_active][i]  = g;
            mknown[~m_active][i] = 1'b1;
        end
    endtask

    task automatic do_write(input int a, input logic [15:0] g);
        send_cmd(2'b00, a, g);
        mbank[~m_active][a]  = g;
        mknown[~m_active][a] = 1'b1;
        tick();
        tick();
    endtask

    task automatic do_fill(input logic [15:0] g);
        send_cmd(2'b01, 0, g);
        model_fill(g);
        wait_idle(NCH + 50, "fill_done");
    endtask

    // Sync arrives k cycles after the first ARM cycle.
    task automatic do_commit(input int k);
        send_cmd(2'b10, 0, 16'h0);
        repeat (k + 1) tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        m_active = ~m_active;
        m_cnt    = m_cnt + 16'd1;
    endtask

    task automatic do_read(input int a);
        rd_exp_t e;
        if (mknown[m_active][a]) begin
            e.addr  = a;
            e.data  = mbank[m_active][a];
            rd_addr = a[9:0];
            rd_req  = 1'b1;
            sb_q.push_back(e);
            tick();
            rd_req = 1'b0;
        end
    endtask

    task automatic check_status(input string name);
        logic [31:0] e;
        tick();
        tick();
        e        = '0;
        e[29]    = m_err;
        e[28]    = m_active;
        e[15:0]  = m_cnt;
        chk({name, "_status"}, status_word, e);
        chk({name, "_bank"}, {31'b0, active_bank}, {31'b0, m_active});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          a;
        int          r;
        logic [15:0] g;

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NCH; i++) begin
                mknown[b][i] = 1'b0;
                mbank[b][i]  = '0;
            end

        // Reset with the toggle bit held high and a fill op on the bus.
        OPB_Rst         = 1'b1;
        sync_in         = 1'b0;
        rd_addr         = '0;
        tog             = 1'b1;
        cmd_word        = '0;
        cmd_word[31]    = 1'b1;
        cmd_word[30:29] = 2'b01;
        repeat (3) tick();
        OPB_Rst = 1'b0;
        repeat (6) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        check_status("rst");

        // Single write, commit, read back.
        do_write(5, 16'h1234);
        do_commit(0);
        check_status("commit1");
        do_read(5);
        repeat (3) tick();

        // Fill plus commit: busy spans the whole fill and the ARM wait.
        k = $urandom_range(0, 5);
        busy_cycles = 0;
        do_fill(16'h00AA);
        do_commit(k);
        tick();
        tick();
        chk("busy_cycles", busy_cycles, NCH + k + 1);
        do_read(0);
        do_read(511);
        do_read(1023);
        check_status("fill");

        // Populate the other bank completely.
        do_fill(16'($urandom));
        do_commit($urandom_range(0, 3));
        for (int i = 0; i < 6; i++) do_read($urandom_range(0, NCH - 1));

        // Sync in the acceptance cycle of a commit is ignored.
        send_cmd(2'b10, 0, 16'h0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        repeat (3) tick();
        chk("pend_bit", {31'b0, status_word[30]}, 32'd1);
        chk("pend_bank", {31'b0, active_bank}, {31'b0, m_active});
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        m_active = ~m_active;
        m_cnt    = m_cnt + 16'd1;
        check_status("pend_swap");

        // Command during FILL is dropped and flags err.
        g = 16'($urandom);
        a = $urandom_range(0, NCH - 1);
        send_cmd(2'b01, 0, g);
        model_fill(g);
        repeat (20) tick();
        send_cmd(2'b00, a, ~g);
        m_err = 1'b1;
        chk("drop_busy", {31'b0, busy}, 32'd1);
        wait_idle(NCH + 50, "fill_after_drop");
        check_status("drop");
        do_commit(1);
        do_read(a);
        do_read((a + 1) % NCH);
        repeat (3) tick();
        send_cmd(2'b11, 0, 16'h0);
        m_err = 1'b0;
        check_status("clr_err");

        // Randomized mix of writes, commits and reads.
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                do_write($urandom_range(0, NCH - 1), 16'($urandom));
            end else if (r < 7) begin
                do_commit($urandom_range(0, 3));
            end else begin
                repeat ($urandom_range(1, 3)) do_read($urandom_range(0, NCH - 1));
            end
        end
        repeat (3) tick();
        check_status("random");

        // Reset in ARM aborts the swap but keeps RAM contents.
        if (m_active) do_commit(0);
        a = $urandom_range(0, NCH - 1);
        g = 16'($urandom);
        do_write(a, g);
        send_cmd(2'b10, 0, 16'h0);
        tick();
        tick();
        chk("arm_pend", {31'b0, status_word[30]}, 32'd1);
        OPB_Rst = 1'b1;
        tick();
        tick();
        chk("rst_arm_bank", {31'b0, active_bank}, 32'd0);
        chk("rst_arm_status", status_word, 32'd0);
        OPB_Rst  = 1'b0;
        m_active = 1'b0;
        m_cnt    = 16'd0;
        m_err    = 1'b0;
        repeat (3) tick();
        check_status("post_rst");
        do_commit(2);
        do_read(a);
        do_read($urandom_range(0, NCH - 1));
        check_status("post_rst_commit");
        repeat (4) tick();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: %0d reads left, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
